// File: rtl/memory_sequencer_pkg.sv
// Shared types and defaults for the BRAM initiator and the memories it drives.
package memory_sequencer_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } seq_state_e;

endpackage

// File: rtl/memory_sequencer_addr_gen.sv
// Burst address register with wrap-around increment and beat down-counter.
module burst_addr_gen #(
  parameter int AddrWidth = 8,
  parameter int LenWidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_o
);

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = len_i;
    end else if (step_i) begin
      // Natural overflow gives the modulo-2^AddrWidth wrap.
      addr_d = addr_q + AddrWidth'(1);
      cnt_d  = cnt_q - LenWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/memory_sequencer.sv
// Host request/ready to BRAM strobe sequencer with read and fill bursts.
module memory_sequencer
  import memory_sequencer_pkg::*;
#(
  parameter int AddrWidth = ADDR_W,
  parameter int DataWidth = DATA_W,
  parameter int LenWidth  = LEN_W
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 Req,
  output logic                 Req_Ready,
  input  logic                 Req_Write,
  input  logic [AddrWidth-1:0] Req_Addr,
  input  logic [DataWidth-1:0] Req_Data,
  input  logic [LenWidth-1:0]  Req_Len,
  output logic [DataWidth-1:0] Rd_Data,
  output logic                 Rd_Valid,
  output logic                 Done,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_DIn,
  output logic                 Mem_Write_EN,
  output logic                 Mem_En,
  input  logic [DataWidth-1:0] Mem_DOut
);

  seq_state_e           state_q, state_d;
  logic                 en_q, en_d;
  logic                 we_q, we_d;
  logic                 wr_q, wr_d;
  logic [DataWidth-1:0] din_q, din_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 done_q, done_d;

  logic accept;
  logic load;
  logic step;
  logic last;

  assign Req_Ready = (state_q == IDLE) && Reset_N;
  assign accept    = Req && Req_Ready;

  burst_addr_gen #(
    .AddrWidth(AddrWidth),
    .LenWidth (LenWidth)
  ) u_addr_gen (
    .clk   (Clk),
    .rst_n (Reset_N),
    .load_i(load),
    .step_i(step),
    .addr_i(Req_Addr),
    .len_i (Req_Len),
    .addr_o(Mem_Addr),
    .last_o(last)
  );

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    we_d       = we_q;
    wr_d       = wr_q;
    din_d      = din_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      IDLE: begin
        en_d = STROBE_OFF;
        we_d = STROBE_OFF;
        if (accept) begin
          load    = 1'b1;
          wr_d    = Req_Write;
          din_d   = Req_Data;
          en_d    = STROBE_ON;
          we_d    = Req_Write ? STROBE_ON : STROBE_OFF;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Memory acted at the negedge; DOut is stable here.
        if (!wr_q) begin
          rd_data_d  = Mem_DOut;
          rd_valid_d = 1'b1;
        end
        if (!last) begin
          step = 1'b1;
        end else begin
          en_d    = STROBE_OFF;
          we_d    = STROBE_OFF;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= IDLE;
      en_q       <= STROBE_OFF;
      we_q       <= STROBE_OFF;
      wr_q       <= 1'b0;
      din_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      we_q       <= we_d;
      wr_q       <= wr_d;
      din_q      <= din_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign Mem_En       = en_q;
  assign Mem_Write_EN = we_q;
  assign Mem_DIn      = din_q;
  assign Rd_Data      = rd_data_q;
  assign Rd_Valid     = rd_valid_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed and random checks of memory_sequencer against a BRAM and
// a reference memory image.
module tb_memory_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b1;
  logic        Req = 1'b0;
  logic        Req_Ready;
  logic        Req_Write = 1'b0;
  logic [7:0]  Req_Addr = '0;
  logic [15:0] Req_Data = '0;
  logic [7:0]  Req_Len = '0;
  logic [15:0] Rd_Data;
  logic        Rd_Valid;
  logic        Done;
  logic [7:0]  Mem_Addr;
  logic [15:0] Mem_DIn;
  logic        Mem_Write_EN;
  logic        Mem_En;
  logic [15:0] Mem_DOut = '0;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  int          wr_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 Clk = ~Clk;

  memory_sequencer dut (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .Req         (Req),
    .Req_Ready   (Req_Ready),
    .Req_Write   (Req_Write),
    .Req_Addr    (Req_Addr),
    .Req_Data    (Req_Data),
    .Req_Len     (Req_Len),
    .Rd_Data     (Rd_Data),
    .Rd_Valid    (Rd_Valid),
    .Done        (Done),
    .Mem_Addr    (Mem_Addr),
    .Mem_DIn     (Mem_DIn),
    .Mem_Write_EN(Mem_Write_EN),
    .Mem_En      (Mem_En),
    .Mem_DOut    (Mem_DOut)
  );

  // Single-port synchronous BRAM, acting on the falling edge.
  always @(negedge Clk) begin
    if (Mem_En === 1'b0) begin
      if (Mem_Write_EN === 1'b0) begin
        mem[Mem_Addr] <= Mem_DIn;
        wr_cnt <= wr_cnt + 1;
      end else begin
        Mem_DOut <= mem[Mem_Addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one request and check every beat; optionally keep a busy-time
  // request asserted throughout and leave it asserted on return.
  task automatic do_req(input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic [7:0] len,
                        input bit poke);
    int n;
    int waited;
    logic [7:0] ea;
    n = int'(len) + 1;
    waited = 0;
    Req = 1'b1;
    Req_Write = wr;
    Req_Addr = a;
    Req_Data = d;
    Req_Len = len;
    while (Req_Ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    chk("ready_before_accept", Req_Ready, 1);
    tick();
    if (poke) begin
      Req_Write = 1'b1;
      Req_Addr = 8'h55;
      Req_Data = 16'hDEAD;
      Req_Len = 8'd0;
    end else begin
      Req = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      ea = a + 8'(i);
      chk("beat_en", Mem_En, 0);
      chk("beat_addr", Mem_Addr, ea);
      chk("beat_we", Mem_Write_EN, wr ? 0 : 1);
      if (wr) chk("beat_din", Mem_DIn, d);
      if (i == 0 || poke) chk("busy_ready", Req_Ready, 0);
      chk("beat_done", Done, 0);
      chk("beat_rv", Rd_Valid, (i > 0 && !wr) ? 1 : 0);
      if (i > 0 && !wr) chk("beat_rdata", Rd_Data, ref_mem[ea - 8'd1]);
      if (wr) ref_mem[ea] = d;
      tick();
    end
    ea = a + 8'(n - 1);
    chk("end_done", Done, 1);
    chk("end_en", Mem_En, 1);
    chk("end_we", Mem_Write_EN, 1);
    chk("end_rv", Rd_Valid, wr ? 0 : 1);
    if (!wr) chk("end_rdata", Rd_Data, ref_mem[ea]);
    chk("end_ready", Req_Ready, 1);
    if (!poke) begin
      tick();
      chk("idle_done", Done, 0);
      chk("idle_rv", Rd_Valid, 0);
      chk("idle_en", Mem_En, 1);
    end
  endtask

  initial begin
    int w0;
    int dones;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset held with a pending request.
    Reset_N = 1'b0;
    Req = 1'b1;
    Req_Write = 1'b1;
    Req_Addr = 8'h33;
    Req_Data = 16'h1234;
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_en", Mem_En, 1);
      chk("rst_we", Mem_Write_EN, 1);
      chk("rst_rv", Rd_Valid, 0);
      chk("rst_done", Done, 0);
      chk("rst_ready", Req_Ready, 0);
    end
    chk("rst_rdata", Rd_Data, 0);
    chk("rst_addr", Mem_Addr, 0);
    chk("rst_din", Mem_DIn, 0);
    chk("rst_nowrite", wr_cnt, w0);
    Req = 1'b0;
    Reset_N = 1'b1;
    #1;
    chk("post_rst_ready", Req_Ready, 1);
    tick();

    // Single write, then read back.
    do_req(1'b1, 8'h10, 16'hBEEF, 8'd0, 1'b0);
    do_req(1'b0, 8'h10, 16'h0000, 8'd0, 1'b0);
    tick();
    chk("beef_readback", Rd_Data, 16'hBEEF);

    // Fill burst and surrounding read.
    w0 = wr_cnt;
    do_req(1'b1, 8'h20, 16'h0000, 8'd7, 1'b0);
    chk("fill_writes", wr_cnt - w0, 8);
    do_req(1'b0, 8'h1F, 16'h0000, 8'd9, 1'b0);

    // Address wrap-around.
    do_req(1'b0, 8'hFE, 16'h0000, 8'd3, 1'b0);

    // Busy rejection, then immediate acceptance of the held request.
    w0 = wr_cnt;
    do_req(1'b0, 8'h60, 16'h0000, 8'd3, 1'b1);
    chk("busy_nowrite", wr_cnt, w0);
    do_req(1'b0, 8'h55, 16'h0000, 8'd0, 1'b0);
    chk("busy_untouched", ref_mem[8'h55] === 16'hDEAD ? 0 : 1, 1);

    // Random mixed traffic.
    for (int k = 0; k < 8; k++) begin
      do_req(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
             8'($urandom_range(0, 12)), 1'b0);
    end

    // Longest burst: every address read once.
    do_req(1'b0, 8'($urandom), 16'h0000, 8'hFF, 1'b0);

    // Reset in the middle of a long read burst.
    Req = 1'b1;
    Req_Write = 1'b0;
    Req_Addr = 8'h00;
    Req_Len = 8'd15;
    tick();
    Req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_en", Mem_En, 0);
      tick();
    end
    chk("mid_rv", Rd_Valid, 1);
    Reset_N = 1'b0;
    #1;
    chk("mid_rst_en", Mem_En, 1);
    chk("mid_rst_we", Mem_Write_EN, 1);
    chk("mid_rst_ready", Req_Ready, 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Done !== 1'b0) dones++;
    end
    Reset_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Done !== 1'b0) dones++;
    end
    chk("mid_rst_nodone", dones, 0);
    do_req(1'b0, 8'h10, 16'h0000, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
